// File: rtl/otf_sd_converter.sv
// MSB-first signed-digit to two's-complement on-the-fly converter (Q/QM method).
// Optional macro OTF_QM_OUT_EN exposes QM (result-1) as output result_m1.
module otf_sd_converter #(
  parameter int NDIGITS = 8,
  parameter int CNT_W   = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               d_valid,
  input  logic               d_plus,
  input  logic               d_minus,
  output logic               busy,
  output logic [NDIGITS:0]   result,
  output logic               result_valid,
`ifdef OTF_QM_OUT_EN
  output logic [NDIGITS:0]   result_m1,
`endif
  output logic [CNT_W-1:0]   digit_cnt
);

  localparam int W = NDIGITS + 1;

  typedef enum logic [1:0] {S_IDLE, S_CONVERT, S_DONE} state_t;

  state_t           r_state, w_state_nxt;
  logic [W-1:0]     r_q, r_qm, w_q_nxt, w_qm_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             w_pos, w_neg, w_last;

  // plus=minus=1 decodes to digit 0, same as plus=minus=0
  assign w_pos  = d_plus & ~d_minus;
  assign w_neg  = d_minus & ~d_plus;
  assign w_last = (r_cnt == CNT_W'(NDIGITS - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_q     <= '0;
      r_qm    <= '1;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_q     <= w_q_nxt;
      r_qm    <= w_qm_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // start outranks d_valid in every state; a digit presented with start is dropped
  always_comb begin
    w_state_nxt = r_state;
    w_q_nxt     = r_q;
    w_qm_nxt    = r_qm;
    w_cnt_nxt   = r_cnt;
    if (start) begin
      w_state_nxt = S_CONVERT;
      w_q_nxt     = '0;
      w_qm_nxt    = '1;
      w_cnt_nxt   = '0;
    end else begin
      unique case (r_state)
        S_IDLE: ;
        S_CONVERT: begin
          if (d_valid) begin
            // each branch only shifts and selects, so QM == Q-1 is preserved with no carry chain
            if (w_pos) begin
              w_q_nxt  = {r_q[W-2:0], 1'b1};
              w_qm_nxt = {r_q[W-2:0], 1'b0};
            end else if (w_neg) begin
              w_q_nxt  = {r_qm[W-2:0], 1'b1};
              w_qm_nxt = {r_qm[W-2:0], 1'b0};
            end else begin
              w_q_nxt  = {r_q[W-2:0], 1'b0};
              w_qm_nxt = {r_qm[W-2:0], 1'b1};
            end
            w_cnt_nxt = r_cnt + CNT_W'(1);
            if (w_last) w_state_nxt = S_DONE;
          end
        end
        S_DONE:  w_state_nxt = S_IDLE;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  assign busy         = (r_state == S_CONVERT);
  assign result_valid = (r_state == S_DONE);
  assign result       = r_q;
  assign digit_cnt    = r_cnt;
`ifdef OTF_QM_OUT_EN
  assign result_m1    = r_qm;
`endif

endmodule

// File: tb/tb_otf_sd_converter.sv
// Directed, table-driven bench for otf_sd_converter at NDIGITS=4.
module tb_otf_sd_converter;

  localparam int ND = 4;
  localparam int CW = 4;

  logic          clk, reset, start, d_valid, d_plus, d_minus;
  logic          busy, result_valid;
  logic [ND:0]   result;
  logic [CW-1:0] digit_cnt;
`ifdef OTF_QM_OUT_EN
  logic [ND:0]   result_m1;
`endif

  otf_sd_converter #(.NDIGITS(ND), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .start(start), .d_valid(d_valid),
    .d_plus(d_plus), .d_minus(d_minus), .busy(busy), .result(result),
    .result_valid(result_valid),
`ifdef OTF_QM_OUT_EN
    .result_m1(result_m1),
`endif
    .digit_cnt(digit_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic st, dv, p, m;
    logic eb, ev;
    logic [ND:0] er, em;
    logic [CW-1:0] ec;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic st, dv, p, m, eb, ev,
                              input logic [ND:0] er, em, input logic [CW-1:0] ec);
    vec_t v;
    v.st = st; v.dv = dv; v.p = p; v.m = m;
    v.eb = eb; v.ev = ev; v.er = er; v.em = em; v.ec = ec;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_outs(input string tag, input logic eb, ev,
                          input logic [ND:0] er, em, input logic [CW-1:0] ec);
    chk({tag, " busy"},      32'(busy), 32'(eb));
    chk({tag, " valid"},     32'(result_valid), 32'(ev));
    chk({tag, " result"},    32'(result), 32'(er));
    chk({tag, " digit_cnt"}, 32'(digit_cnt), 32'(ec));
`ifdef OTF_QM_OUT_EN
    chk({tag, " result_m1"}, 32'(result_m1), 32'(em));
`else
    chk({tag, " qm"},        32'(dut.r_qm), 32'(em));
`endif
  endtask

  // drive one cycle of inputs, clock it, then sample just after the edge
  task automatic step(input string tag, input logic st, dv, p, m, eb, ev,
                      input logic [ND:0] er, em, input logic [CW-1:0] ec);
    start = st; d_valid = dv; d_plus = p; d_minus = m;
    @(posedge clk); #1;
    chk_outs(tag, eb, ev, er, em, ec);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; d_valid = 1'b0; d_plus = 1'b0; d_minus = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_outs("reset", 1'b0, 1'b0, 5'h00, 5'h1f, 4'd0);
    reset = 1'b0;

    // st dv p m | busy valid result qm cnt
    tbl.push_back(mk(0,1,1,0, 0,0, 5'h00,5'h1f,4'd0)); // d_valid ignored in IDLE
    tbl.push_back(mk(1,0,0,0, 1,0, 5'h00,5'h1f,4'd0)); // +1,0,-1,+1 -> 7
    tbl.push_back(mk(0,1,1,0, 1,0, 5'h01,5'h00,4'd1));
    tbl.push_back(mk(0,1,0,0, 1,0, 5'h02,5'h01,4'd2));
    tbl.push_back(mk(0,1,0,1, 1,0, 5'h03,5'h02,4'd3));
    tbl.push_back(mk(0,1,1,0, 0,1, 5'h07,5'h06,4'd4));
    tbl.push_back(mk(0,0,0,0, 0,0, 5'h07,5'h06,4'd4)); // held in IDLE
    tbl.push_back(mk(1,0,0,0, 1,0, 5'h00,5'h1f,4'd0)); // -1 x4 -> -15
    tbl.push_back(mk(0,1,0,1, 1,0, 5'h1f,5'h1e,4'd1));
    tbl.push_back(mk(0,1,0,1, 1,0, 5'h1d,5'h1c,4'd2));
    tbl.push_back(mk(0,1,0,1, 1,0, 5'h19,5'h18,4'd3));
    tbl.push_back(mk(0,1,0,1, 0,1, 5'h11,5'h10,4'd4));
    tbl.push_back(mk(1,0,0,0, 1,0, 5'h00,5'h1f,4'd0)); // start in DONE -> CONVERT
    tbl.push_back(mk(0,1,1,1, 1,0, 5'h00,5'h1f,4'd1)); // plus=minus=1 x4 -> 0
    tbl.push_back(mk(0,1,1,1, 1,0, 5'h00,5'h1f,4'd2));
    tbl.push_back(mk(0,1,1,1, 1,0, 5'h00,5'h1f,4'd3));
    tbl.push_back(mk(0,1,1,1, 0,1, 5'h00,5'h1f,4'd4));
    tbl.push_back(mk(0,0,0,0, 0,0, 5'h00,5'h1f,4'd4));

    foreach (tbl[i])
      step($sformatf("tbl[%0d]", i), tbl[i].st, tbl[i].dv, tbl[i].p, tbl[i].m,
           tbl[i].eb, tbl[i].ev, tbl[i].er, tbl[i].em, tbl[i].ec);

    // +1,-1,-1,-1 with two stall cycles between digits -> 1
    step("stall start", 1,0,0,0, 1,0, 5'h00,5'h1f,4'd0);
    step("stall d0",    0,1,1,0, 1,0, 5'h01,5'h00,4'd1);
    for (int k = 1; k < 4; k++) begin
      step($sformatf("stall gap%0da", k), 0,0,1,0, 1,0, 5'h01,5'h00,4'(k));
      step($sformatf("stall gap%0db", k), 0,0,0,1, 1,0, 5'h01,5'h00,4'(k));
      step($sformatf("stall d%0d", k),    0,1,0,1, (k != 3), (k == 3), 5'h01,5'h00,4'(k+1));
    end
    step("stall idle", 0,0,0,0, 0,0, 5'h01,5'h00,4'd4);

    // abort after two digits; digit presented with start is dropped
    step("rst start", 1,0,0,0, 1,0, 5'h00,5'h1f,4'd0);
    step("rst d0",    0,1,1,0, 1,0, 5'h01,5'h00,4'd1);
    step("rst d1",    0,1,1,0, 1,0, 5'h03,5'h02,4'd2);
    step("rst abort", 1,1,1,0, 1,0, 5'h00,5'h1f,4'd0);
    step("rst d2",    0,1,0,0, 1,0, 5'h00,5'h1f,4'd1);
    step("rst d3",    0,1,0,0, 1,0, 5'h00,5'h1f,4'd2);
    step("rst d4",    0,1,0,0, 1,0, 5'h00,5'h1f,4'd3);
    step("rst d5",    0,1,1,0, 0,1, 5'h01,5'h00,4'd4);
    step("rst idle",  0,0,0,0, 0,0, 5'h01,5'h00,4'd4);

    // asynchronous reset after the third digit, then a clean +1 x4 -> 15
    step("ar start", 1,0,0,0, 1,0, 5'h00,5'h1f,4'd0);
    step("ar d0",    0,1,1,0, 1,0, 5'h01,5'h00,4'd1);
    step("ar d1",    0,1,1,0, 1,0, 5'h03,5'h02,4'd2);
    step("ar d2",    0,1,1,0, 1,0, 5'h07,5'h06,4'd3);
    reset = 1'b1;
    #1;
    chk_outs("ar async", 1'b0, 1'b0, 5'h00, 5'h1f, 4'd0);
    step("ar held",  0,1,1,0, 0,0, 5'h00,5'h1f,4'd0);
    reset = 1'b0;
    step("ar2 start", 1,0,0,0, 1,0, 5'h00,5'h1f,4'd0);
    step("ar2 d0",    0,1,1,0, 1,0, 5'h01,5'h00,4'd1);
    step("ar2 d1",    0,1,1,0, 1,0, 5'h03,5'h02,4'd2);
    step("ar2 d2",    0,1,1,0, 1,0, 5'h07,5'h06,4'd3);
    step("ar2 d3",    0,1,1,0, 0,1, 5'h0f,5'h0e,4'd4);
    step("ar2 idle",  0,0,0,0, 0,0, 5'h0f,5'h0e,4'd4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
